uart_cmd_encoder: RTL and testbench

UART_CMD_ENCODER -- requirements
Module: uart_cmd_encoder

---
 rtl/uart_cmd_pkg.sv | 39 +++
 rtl/uart_cmd_watchdog.sv | 28 ++
 rtl/uart_cmd_encoder.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_encoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command encoder: command byte codes (must match
// the receiver), command-select and FSM state enums, and the latched request record.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_DATA   = 8'hD1;
    localparam logic [7:0] CMD_CTRL   = 8'hD2;
    localparam logic [7:0] CMD_FREQ   = 8'hD3;
    localparam logic [7:0] CMD_PERIOD = 8'hD4;
    localparam logic [7:0] CMD_REPEAT = 8'hD5;
    localparam logic [7:0] CMD_GLOBAL = 8'hD6;

    typedef enum logic [2:0] {
        SEL_DATA   = 3'd0,
        SEL_FREQ   = 3'd1,
        SEL_PERIOD = 3'd2,
        SEL_REPEAT = 3'd3,
        SEL_GLOBAL = 3'd4
    } cmd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    typedef struct packed {
        cmd_sel_e   cmd;
        logic [7:0] channel;
        logic [7:0] amount;
        logic [7:0] arg0;
        logic [7:0] arg1;
        logic [3:0] ctrl;
    } req_t;

    function automatic logic cmd_legal(input logic [2:0] sel);
        return sel <= 3'd4;
    endfunction

endpackage

// File: rtl/uart_cmd_watchdog.sv
// tx_done watchdog: counts cycles while armed and flags expiry so the encoder's
// registered err_tick lands TIMEOUT_CYC cycles after the byte's tx_start.
module uart_cmd_watchdog #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic arm,
    input  logic kick,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n)
            cnt <= '0;
        else if (!arm || kick)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + 1'b1;
    end

    // arm rises one cycle after tx_start, and err_tick is registered one cycle after expire
    assign expire = arm && (cnt == CW'(TIMEOUT_CYC - 2));

endmodule

// File: rtl/uart_cmd_encoder.sv
// Serialises host command requests into UART byte frames over a start/done handshake.
// Define UART_CMD_ENCODER_TIMEOUT_EN to build in the per-byte tx_done watchdog.
module uart_cmd_encoder
    import uart_cmd_pkg::*;
#(
    parameter int DATA_BIT    = 64,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [2:0]          cmd_sel_i,
    input  logic [7:0]          channel_i,
    input  logic [7:0]          amount_i,
    input  logic [DATA_BIT-1:0] pattern_i,
    input  logic [7:0]          arg0_i,
    input  logic [7:0]          arg1_i,
    input  logic [3:0]          ctrl_i,
    output logic                tx_start_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_done_tick_i,
    output logic                frame_done_tick_o,
    output logic                err_tick_o
);
    localparam int NBYTES = DATA_BIT / 8;

    if ((DATA_BIT % 8) != 0 || DATA_BIT < 8 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("uart_cmd_encoder: DATA_BIT must be a positive multiple of 8, TIMEOUT_CYC >= 2");
    end

    state_e              state;
    req_t                req_d, req_q;
    logic [DATA_BIT-1:0] pattern_q;
    logic [7:0]          byte_idx, last_idx;
    logic                accept, req_bad;

    function automatic logic [7:0] pat_byte(input logic [DATA_BIT-1:0] pat, input int k);
        logic [DATA_BIT-1:0] sh;
        sh = pat >> (8 * k);
        return sh[7:0];
    endfunction

    // Index of the final byte of a frame (frame length minus one)
    function automatic logic [7:0] frame_last(input req_t r);
        case (r.cmd)
            SEL_DATA:               return r.amount + 8'd6;
            SEL_FREQ:               return r.amount + 8'd2;
            SEL_PERIOD, SEL_REPEAT: return 8'd2;
            default:                return 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input req_t r, input logic [DATA_BIT-1:0] pat,
                                              input logic [7:0] idx);
        int         i, a;
        logic [7:0] b;
        i = int'(idx);
        a = int'(r.amount);
        b = 8'h00;
        case (r.cmd)
            SEL_DATA: begin
                if (i == 0)          b = CMD_DATA;
                else if (i == 1)     b = r.channel;
                else if (i == 2)     b = r.amount;
                else if (i <= a + 3) b = pat_byte(pat, i - 3);
                else if (i == a + 4) b = CMD_CTRL;
                else if (i == a + 5) b = r.channel;
                else                 b = {4'h0, r.ctrl};
            end
            SEL_FREQ: begin
                if (i == 0)      b = CMD_FREQ;
                else if (i == 1) b = r.amount;
                else             b = pat_byte(pat, i - 2);
            end
            SEL_PERIOD: begin
                if (i == 0)      b = CMD_PERIOD;
                else if (i == 1) b = r.arg0;
                else             b = r.arg1;
            end
            SEL_REPEAT: begin
                if (i == 0)      b = CMD_REPEAT;
                else if (i == 1) b = r.channel;
                else             b = r.arg0;
            end
            default: begin
                if (i == 0)      b = CMD_GLOBAL;
                else             b = {7'h0, r.arg0[0]};
            end
        endcase
        return b;
    endfunction

    always_comb begin
        req_d         = '0;
        req_d.cmd     = cmd_sel_e'(cmd_sel_i);
        req_d.channel = channel_i;
        req_d.amount  = amount_i;
        req_d.arg0    = arg0_i;
        req_d.arg1    = arg1_i;
        req_d.ctrl    = ctrl_i;
    end

    assign accept  = req_valid_i && req_ready_o;
    assign req_bad = !cmd_legal(cmd_sel_i) || (int'(amount_i) > NBYTES - 1);

`ifdef UART_CMD_ENCODER_TIMEOUT_EN
    logic wd_expire;

    uart_cmd_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .arm   (state == ST_WAIT_DONE),
        .kick  (tx_done_tick_i),
        .expire(wd_expire)
    );
`endif

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            state             <= ST_IDLE;
            req_q             <= '0;
            pattern_q         <= '0;
            byte_idx          <= '0;
            last_idx          <= '0;
            req_ready_o       <= 1'b1;
            tx_start_o        <= 1'b0;
            tx_data_o         <= 8'h00;
            frame_done_tick_o <= 1'b0;
            err_tick_o        <= 1'b0;
        end else begin
            tx_start_o        <= 1'b0;
            frame_done_tick_o <= 1'b0;
            err_tick_o        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        byte_idx <= '0;
                        // Bad requests are consumed without sending; ready stays high
                        if (req_bad) begin
                            err_tick_o <= 1'b1;
                        end else begin
                            req_q       <= req_d;
                            pattern_q   <= pattern_i;
                            last_idx    <= frame_last(req_d);
                            tx_start_o  <= 1'b1;
                            tx_data_o   <= frame_byte(req_d, pattern_i, 8'd0);
                            req_ready_o <= 1'b0;
                            state       <= ST_SEND;
                        end
                    end
                end
                ST_SEND: state <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (tx_done_tick_i) begin
                        if (byte_idx == last_idx) begin
                            frame_done_tick_o <= 1'b1;
                            req_ready_o       <= 1'b1;
                            byte_idx          <= '0;
                            state             <= ST_IDLE;
                        end else begin
                            byte_idx   <= byte_idx + 8'd1;
                            tx_start_o <= 1'b1;
                            tx_data_o  <= frame_byte(req_q, pattern_q, byte_idx + 8'd1);
                            state      <= ST_SEND;
                        end
                    end
`ifdef UART_CMD_ENCODER_TIMEOUT_EN
                    else if (wd_expire) begin
                        err_tick_o  <= 1'b1;
                        req_ready_o <= 1'b1;
                        byte_idx    <= '0;
                        state       <= ST_IDLE;
                    end
`endif
                end
                default: begin
                    req_ready_o <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_encoder.sv
// Self-checking bench for uart_cmd_encoder: a UART TX responder plus a frame-level
// reference model built from the command layouts; watchdog scenario under the macro.
module tb_uart_cmd_encoder;

    localparam int DATA_BIT = 64;
    localparam int NB       = DATA_BIT / 8;
    localparam int TB_TO    = 50;

    localparam logic [7:0] E_DATA   = 8'hD1;
    localparam logic [7:0] E_CTRL   = 8'hD2;
    localparam logic [7:0] E_FREQ   = 8'hD3;
    localparam logic [7:0] E_PERIOD = 8'hD4;
    localparam logic [7:0] E_REPEAT = 8'hD5;
    localparam logic [7:0] E_GLOBAL = 8'hD6;

    logic                clk_i = 1'b0;
    logic                rst_n;
    logic                req_valid_i, req_ready_o;
    logic [2:0]          cmd_sel_i;
    logic [7:0]          channel_i, amount_i, arg0_i, arg1_i;
    logic [DATA_BIT-1:0] pattern_i;
    logic [3:0]          ctrl_i;
    logic                tx_start_o, tx_done_tick_i;
    logic [7:0]          tx_data_o;
    logic                frame_done_tick_o, err_tick_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    uart_cmd_encoder #(.DATA_BIT(DATA_BIT), .TIMEOUT_CYC(TB_TO)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .cmd_sel_i(cmd_sel_i), .channel_i(channel_i), .amount_i(amount_i),
        .pattern_i(pattern_i), .arg0_i(arg0_i), .arg1_i(arg1_i), .ctrl_i(ctrl_i),
        .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_done_tick_i(tx_done_tick_i),
        .frame_done_tick_o(frame_done_tick_o), .err_tick_o(err_tick_o)
    );

    // Reference model: expected byte sequence of a frame
    logic [7:0] exp_q[$];
    bit         exp_bad;

    function automatic void model(input logic [2:0] cmd, input logic [7:0] ch, input logic [7:0] amt,
                                  input logic [DATA_BIT-1:0] pat, input logic [7:0] a0,
                                  input logic [7:0] a1, input logic [3:0] ctrl);
        exp_q.delete();
        exp_bad = (cmd > 3'd4) || (int'(amt) > NB - 1);
        if (exp_bad) return;
        case (cmd)
            3'd0: begin
                exp_q.push_back(E_DATA); exp_q.push_back(ch); exp_q.push_back(amt);
                for (int i = 0; i <= int'(amt); i++) exp_q.push_back(pat[8*i +: 8]);
                exp_q.push_back(E_CTRL); exp_q.push_back(ch); exp_q.push_back({4'h0, ctrl});
            end
            3'd1: begin
                exp_q.push_back(E_FREQ); exp_q.push_back(amt);
                for (int i = 0; i <= int'(amt); i++) exp_q.push_back(pat[8*i +: 8]);
            end
            3'd2: begin exp_q.push_back(E_PERIOD); exp_q.push_back(a0); exp_q.push_back(a1); end
            3'd3: begin exp_q.push_back(E_REPEAT); exp_q.push_back(ch); exp_q.push_back(a0); end
            default: begin exp_q.push_back(E_GLOBAL); exp_q.push_back({7'h0, a0[0]}); end
        endcase
    endfunction

    // Observations of one frame, timed in cycles after the accepting edge
    logic [7:0] got[$];
    int         st_t[$];
    int         fd_t, err_t, extra, rdy0, rdy_end;
    bit         wide, timed_out;

    task automatic issue_req(input logic [2:0] cmd, input logic [7:0] ch, input logic [7:0] amt,
                             input logic [DATA_BIT-1:0] pat, input logic [7:0] a0,
                             input logic [7:0] a1, input logic [3:0] ctrl);
        int w = 0;
        while (!req_ready_o && w < 200) begin @(posedge clk_i); #1; w++; end
        n_checks++;
        if (!req_ready_o) begin
            n_fail++;
            $display("FAIL ready_wait: req_ready_o=%0b after %0d cycles, required 1", req_ready_o, w);
        end
        cmd_sel_i = cmd; channel_i = ch; amount_i = amt; pattern_i = pat;
        arg0_i = a0; arg1_i = a1; ctrl_i = ctrl; req_valid_i = 1'b1;
        model(cmd, ch, amt, pat, a0, a1, ctrl);
        @(posedge clk_i); #1;
        // Scramble the request fields: the frame must come from the latched copy
        req_valid_i = 1'b0;
        cmd_sel_i = 3'($urandom); channel_i = 8'($urandom); amount_i = 8'($urandom);
        pattern_i = {$urandom, $urandom}; arg0_i = 8'($urandom); arg1_i = 8'($urandom);
        ctrl_i = 4'($urandom);
    endtask

    // UART TX responder: acks each start after 'gap' cycles (gap 0 = never ack)
    task automatic run_frame(input int gap, input bit noise, input int stop_after);
        int t = 0, done_at = -1, ndone = 0, post = -1;
        bit prev = 1'b0;
        got.delete(); st_t.delete();
        fd_t = -1; err_t = -1; extra = 0; wide = 1'b0; timed_out = 1'b0;
        rdy0 = req_ready_o; rdy_end = -1;
        while (1) begin
            if (tx_start_o) begin
                if (prev) wide = 1'b1;
                if (post >= 0) extra++;
                else begin
                    got.push_back(tx_data_o); st_t.push_back(t);
                    if (gap > 0) done_at = t + gap;
                end
            end
            prev = tx_start_o;
            if (frame_done_tick_o && fd_t < 0) begin fd_t = t; rdy_end = req_ready_o; post = 3; end
            if (err_tick_o && err_t < 0) begin err_t = t; rdy_end = req_ready_o; post = 3; end
            if (stop_after > 0 && ndone == stop_after) break;
            tx_done_tick_i = (t == done_at) || (noise && tx_start_o);
            if (t == done_at) ndone++;
            if (post == 0) break;
            if (post > 0) post--;
            if (t > 3000) begin timed_out = 1'b1; break; end
            @(posedge clk_i); #1; t++;
        end
        tx_done_tick_i = 1'b0;
    endtask

    task automatic test_reset;
        n_checks += 5;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b, required 1", req_ready_o); end
        if (tx_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b, required 0", tx_start_o); end
        if (tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, required 00", tx_data_o); end
        if (frame_done_tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_fdone: got %0b, required 0", frame_done_tick_o); end
        if (err_tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b, required 0", err_tick_o); end
    endtask

    // Directed PERIOD/FREQ/DATA frames first, then randomised legal frames
    task automatic test_frames;
        logic [2:0] cmd; logic [7:0] ch, amt, a0, a1; logic [DATA_BIT-1:0] pat; logic [3:0] ctrl;
        int gap; bit noise;
        for (int f = 0; f < 23; f++) begin
            cmd = 3'($urandom_range(0, 4)); ch = 8'($urandom); amt = 8'($urandom_range(0, NB - 1));
            pat = {$urandom, $urandom}; a0 = 8'($urandom); a1 = 8'($urandom); ctrl = 4'($urandom);
            gap = $urandom_range(1, 6); noise = f[0];
            if (f == 0) begin cmd = 3'd2; a0 = 8'h14; a1 = 8'h05; gap = 10; end
            if (f == 1) begin cmd = 3'd1; amt = 8'd2; pat = 64'h5555_5555_5555_5555; gap = 10; end
            if (f == 2) begin cmd = 3'd0; ch = 8'd3; amt = 8'd3; pat = 64'h0101_0101_0101_0155; ctrl = 4'b0101; gap = 10; end
            issue_req(cmd, ch, amt, pat, a0, a1, ctrl);
            run_frame(gap, noise, 0);
            n_checks += 5;
            if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL frame%0d_len: got %0d bytes, required %0d", f, got.size(), exp_q.size()); end
            if (fd_t != exp_q.size() * (gap + 1)) begin n_fail++; $display("FAIL frame%0d_done_time: got %0d, required %0d", f, fd_t, exp_q.size() * (gap + 1)); end
            if (err_t != -1 || extra != 0 || wide || timed_out) begin n_fail++; $display("FAIL frame%0d_clean: err_t=%0d extra=%0d wide=%0b timeout=%0b, required -1/0/0/0", f, err_t, extra, wide, timed_out); end
            if (rdy0 !== 0) begin n_fail++; $display("FAIL frame%0d_busy: ready after accept %0d, required 0", f, rdy0); end
            if (rdy_end !== 1) begin n_fail++; $display("FAIL frame%0d_ready: ready at frame_done %0d, required 1", f, rdy_end); end
            for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
                n_checks += 2;
                if (got[k] !== exp_q[k]) begin n_fail++; $display("FAIL frame%0d_byte%0d: got %h, required %h", f, k, got[k], exp_q[k]); end
                if (st_t[k] != k * (gap + 1)) begin n_fail++; $display("FAIL frame%0d_start%0d: at cycle %0d, required %0d", f, k, st_t[k], k * (gap + 1)); end
            end
        end
    endtask

    task automatic test_errors;
        logic [2:0] cs[4] = '{3'd1, 3'd6, 3'd0, 3'd7};
        logic [7:0] am[4] = '{8'd8, 8'd0, 8'd9, 8'd255};
        for (int e = 0; e < 4; e++) begin
            issue_req(cs[e], 8'h11, am[e], {$urandom, $urandom}, 8'h22, 8'h33, 4'h5);
            run_frame(3, 1'b0, 0);
            n_checks += 4;
            if (!exp_bad) begin n_fail++; $display("FAIL err%0d_model: request judged legal, required illegal", e); end
            if (err_t != 0) begin n_fail++; $display("FAIL err%0d_tick: at cycle %0d, required 0", e, err_t); end
            if (got.size() + extra != 0 || fd_t != -1) begin n_fail++; $display("FAIL err%0d_quiet: %0d starts, fd_t=%0d, required 0/-1", e, got.size() + extra, fd_t); end
            if (rdy0 !== 1) begin n_fail++; $display("FAIL err%0d_ready: got %0d, required 1", e, rdy0); end
        end
    endtask

    task automatic test_reset_abort;
        int starts = 0, ticks = 0;
        issue_req(3'd0, 8'd3, 8'd3, 64'h0101_0101_0101_0155, 8'h0, 8'h0, 4'b0101);
        run_frame(4, 1'b0, 2);
        rst_n = 1'b1; #1;
        test_reset;
        @(posedge clk_i); #1; rst_n = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tx_done_tick_i = (c % 3 == 0);
            starts += tx_start_o; ticks += frame_done_tick_o + err_tick_o;
            @(posedge clk_i); #1;
        end
        tx_done_tick_i = 1'b0;
        n_checks += 2;
        if (got.size() != 3) begin n_fail++; $display("FAIL abort_pre: %0d bytes before reset, required 3", got.size()); end
        if (starts + ticks != 0) begin n_fail++; $display("FAIL abort_quiet: %0d starts %0d ticks, required 0", starts, ticks); end
        issue_req(3'd4, 8'h00, 8'h00, '0, 8'h01, 8'h00, 4'h0);
        run_frame(2, 1'b1, 0);
        n_checks += 3;
        if (got.size() != 2) begin n_fail++; $display("FAIL global_len: got %0d, required 2", got.size()); end
        else if (got[0] !== E_GLOBAL || got[1] !== 8'h01) begin n_fail++; $display("FAIL global_bytes: got %h %h, required %h 01", got[0], got[1], E_GLOBAL); end
        if (fd_t != 6) begin n_fail++; $display("FAIL global_done: at %0d, required 6", fd_t); end
        if (exp_q.size() != 2) begin n_fail++; $display("FAIL global_model: model size %0d, required 2", exp_q.size()); end
    endtask

`ifdef UART_CMD_ENCODER_TIMEOUT_EN
    task automatic test_timeout;
        issue_req(3'd2, 8'h00, 8'h00, '0, 8'h14, 8'h05, 4'h0);
        run_frame(0, 1'b0, 0);
        n_checks += 3;
        if (err_t != TB_TO) begin n_fail++; $display("FAIL timeout_err: at %0d, required %0d", err_t, TB_TO); end
        if (got.size() + extra != 1 || fd_t != -1) begin n_fail++; $display("FAIL timeout_quiet: %0d starts fd_t=%0d, required 1/-1", got.size() + extra, fd_t); end
        if (rdy_end !== 1) begin n_fail++; $display("FAIL timeout_ready: got %0d, required 1", rdy_end); end
    endtask
`endif

    initial begin
        rst_n = 1'b1; req_valid_i = 1'b0; cmd_sel_i = '0; channel_i = '0; amount_i = '0;
        pattern_i = '0; arg0_i = '0; arg1_i = '0; ctrl_i = '0; tx_done_tick_i = 1'b0;
        repeat (3) @(posedge clk_i); #1;
        test_reset;
        rst_n = 1'b0;
        @(posedge clk_i); #1;
        test_frames;
        test_errors;
        test_reset_abort;
`ifdef UART_CMD_ENCODER_TIMEOUT_EN
        test_timeout;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
